// File: rtl/pc_source_unit.sv
// Next-PC source mux with a registered PC, an exception PC and a two-state RUN/EXC controller.
// The mux is combinational; the PC, EPC, cause and nested flag update one cycle after a write or exception.
module pc_source_unit #(
   parameter int               WIDTH    = 32,
   parameter int               NUM_SRC  = 5,
   parameter int               SEL_W    = 3,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               EXC_SEL  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [SEL_W-1:0]         pc_source_control,
   input  logic                     pc_write,
   input  logic                     pc_write_cond,
   input  logic [1:0]               branch_mode,
   input  logic                     alu_zero,
   input  logic                     alu_gt,
   input  logic                     exc_req,
   output logic [WIDTH-1:0]         pc_next,
   output logic [WIDTH-1:0]         pc_out,
   output logic [WIDTH-1:0]         epc_out,
   output logic [1:0]               exc_cause,
   output logic                     in_exc,
   output logic                     nested_exc
);

   typedef enum logic {ST_RUN = 1'b0, ST_EXC = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [1:0]       cause_q, cause_d;
   logic             nested_q, nested_d;
   logic             taken, wr_req, misaligned, exc_sel_hit;

   // Out-of-range selects fall through to the last channel.
   always_comb begin
      pc_next = src_data[(NUM_SRC-1)*WIDTH +: WIDTH];
      for (int k = 0; k < NUM_SRC-1; k++) begin
         if (pc_source_control == SEL_W'(k)) pc_next = src_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      case (branch_mode)
         2'b00:   taken = alu_zero;
         2'b01:   taken = !alu_zero;
         2'b10:   taken = alu_gt;
         default: taken = !alu_gt;
      endcase
   end

   assign wr_req      = pc_write || (pc_write_cond && taken);
   assign misaligned  = wr_req && (pc_next[1:0] != 2'b00);
   assign exc_sel_hit = (pc_source_control == SEL_W'(EXC_SEL));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         epc_q    <= '0;
         cause_q  <= 2'b00;
         nested_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         nested_q <= nested_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (exc_req || misaligned) state_d = ST_EXC;
         default: if (wr_req && exc_sel_hit) state_d = ST_RUN;
      endcase
   end

   // Only the handler-select write leaves EXC; its target is trusted, so alignment is not checked.
   always_comb begin
      pc_d     = pc_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      nested_d = nested_q;
      if (state_q == ST_RUN) begin
         if (exc_req) begin
            epc_d   = pc_q;
            cause_d = 2'b01;
         end else if (misaligned) begin
            epc_d   = pc_q;
            cause_d = 2'b10;
         end else if (wr_req) begin
            pc_d = pc_next;
         end
      end else begin
         if (exc_req || (misaligned && !exc_sel_hit)) nested_d = 1'b1;
         if (wr_req && exc_sel_hit) begin
            pc_d    = pc_next;
            cause_d = 2'b00;
         end
      end
   end

   always_comb begin
      pc_out     = pc_q;
      epc_out    = epc_q;
      exc_cause  = cause_q;
      in_exc     = (state_q == ST_EXC);
      nested_exc = nested_q;
   end

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed bench for pc_source_unit: reference model checked every cycle plus literal spot checks.
module tb_pc_source_unit;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [31:0]  ch [0:4];
   logic [159:0] src_data;
   logic [2:0]   sel = '0;
   logic         pc_write = 1'b0, pc_write_cond = 1'b0;
   logic [1:0]   branch_mode = 2'b00;
   logic         alu_zero = 1'b0, alu_gt = 1'b0, exc_req = 1'b0;
   logic [31:0]  pc_next, pc_out, epc_out;
   logic [1:0]   exc_cause;
   logic         in_exc, nested_exc;

   int checks = 0;
   int passes = 0;
   logic started = 1'b0;

   // Model state
   logic [31:0] m_pc = 32'h0, m_epc = 32'h0;
   logic [1:0]  m_cause = 2'b00;
   logic        m_exc = 1'b0, m_nested = 1'b0;

   assign src_data = {ch[4], ch[3], ch[2], ch[1], ch[0]};

   pc_source_unit dut (
      .clk(clk), .reset(reset), .src_data(src_data), .pc_source_control(sel),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_mode(branch_mode),
      .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_req(exc_req),
      .pc_next(pc_next), .pc_out(pc_out), .epc_out(epc_out), .exc_cause(exc_cause),
      .in_exc(in_exc), .nested_exc(nested_exc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_next();
      int s;
      s = (int'(sel) >= 5) ? 4 : int'(sel);
      return ch[s];
   endfunction

   function automatic bit model_taken();
      case (branch_mode)
         2'd0:    return alu_zero;
         2'd1:    return !alu_zero;
         2'd2:    return alu_gt;
         default: return !alu_gt;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_exc = 1'b0; m_nested = 1'b0;
      end else begin
         logic [31:0] tgt;
         bit req, bad;
         tgt = model_next();
         req = pc_write || (pc_write_cond && model_taken());
         bad = req && (tgt % 4 != 0);
         if (!m_exc) begin
            if (exc_req) begin
               m_epc = m_pc; m_cause = 2'b01; m_exc = 1'b1;
            end else if (bad) begin
               m_epc = m_pc; m_cause = 2'b10; m_exc = 1'b1;
            end else if (req) begin
               m_pc = tgt;
            end
         end else begin
            if (exc_req || (bad && sel != 3'd3)) m_nested = 1'b1;
            if (req && sel == 3'd3) begin
               m_pc = tgt; m_exc = 1'b0; m_cause = 2'b00;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("pc_next", pc_next, model_next());
         check("pc_out", pc_out, m_pc);
         check("epc_out", epc_out, m_epc);
         check("exc_cause", {30'b0, exc_cause}, {30'b0, m_cause});
         check("in_exc", {31'b0, in_exc}, {31'b0, m_exc});
         check("nested_exc", {31'b0, nested_exc}, {31'b0, m_nested});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      pc_write = 1'b0; pc_write_cond = 1'b0; exc_req = 1'b0;
   endtask

   task automatic wr(input logic [2:0] s, input logic [31:0] v);
      sel = s; ch[s] = v; pc_write = 1'b1;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 5; i++) ch[i] = 32'h0;
      #1 reset = 1'b0;
      started = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_pc", pc_out, 32'h0);
      check("rst_in_exc", {31'b0, in_exc}, 32'h0);
      @(negedge clk); #1 reset = 1'b1;

      wr(3'd0, 32'h4);
      check("wr_pc", pc_out, 32'h4);
      check("wr_cause", {30'b0, exc_cause}, 32'h0);

      wr(3'd0, 32'h10);
      sel = 3'd2; ch[2] = 32'h40; branch_mode = 2'b01; alu_zero = 1'b1; pc_write_cond = 1'b1;
      tick();
      check("bne_not_taken", pc_out, 32'h10);
      alu_zero = 1'b0; pc_write_cond = 1'b1;
      tick();
      check("bne_taken", pc_out, 32'h40);
      ch[2] = 32'h44; branch_mode = 2'b10; alu_gt = 1'b1; pc_write_cond = 1'b1;
      tick();
      check("bgt_taken", pc_out, 32'h44);
      ch[2] = 32'h48; branch_mode = 2'b11; pc_write_cond = 1'b1;
      tick();
      check("ble_not_taken", pc_out, 32'h44);
      branch_mode = 2'b00; alu_zero = 1'b0; pc_write_cond = 1'b1;
      tick();
      check("beq_not_taken", pc_out, 32'h44);

      wr(3'd0, 32'h20);
      sel = 3'd0; ch[0] = 32'h24; pc_write = 1'b1; exc_req = 1'b1;
      tick();
      check("exc_pc_hold", pc_out, 32'h20);
      check("exc_epc", epc_out, 32'h20);
      check("exc_cause_ext", {30'b0, exc_cause}, 32'h1);
      check("exc_in_exc", {31'b0, in_exc}, 32'h1);
      wr(3'd1, 32'h50);
      check("exc_ignore_wr", pc_out, 32'h20);
      wr(3'd3, 32'h100);
      check("ret_pc", pc_out, 32'h100);
      check("ret_in_exc", {31'b0, in_exc}, 32'h0);
      check("ret_cause", {30'b0, exc_cause}, 32'h0);

      wr(3'd0, 32'h30);
      wr(3'd1, 32'h32);
      check("mis_pc_hold", pc_out, 32'h30);
      check("mis_epc", epc_out, 32'h30);
      check("mis_cause", {30'b0, exc_cause}, 32'h2);
      exc_req = 1'b1;
      tick();
      check("nested_set", {31'b0, nested_exc}, 32'h1);
      check("nested_epc", epc_out, 32'h30);
      check("nested_cause", {30'b0, exc_cause}, 32'h2);
      wr(3'd3, 32'h101);
      check("ret_unaligned", pc_out, 32'h101);
      check("nested_sticky", {31'b0, nested_exc}, 32'h1);

      ch[4] = 32'hABC;
      for (int s = 5; s < 8; s++) begin
         sel = 3'(s);
         #1 check("sel_clamp", pc_next, 32'hABC);
      end

      exc_req = 1'b1;
      tick();
      check("pre_rst_in_exc", {31'b0, in_exc}, 32'h1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_pc", pc_out, 32'h0);
      check("mid_rst_epc", epc_out, 32'h0);
      check("mid_rst_in_exc", {31'b0, in_exc}, 32'h0);
      check("mid_rst_nested", {31'b0, nested_exc}, 32'h0);
      sel = 3'd2; ch[2] = 32'h77;
      #1 check("rst_pc_next", pc_next, 32'h77);
      @(negedge clk); #1 reset = 1'b1;
      wr(3'd0, 32'h8);
      check("post_rst_run", pc_out, 32'h8);
      check("post_rst_in_exc", {31'b0, in_exc}, 32'h0);

      @(negedge clk); #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
